// File: rtl/pb_debounce_pkg.sv
// Shared definitions for the pushbutton debouncer.
// State encodings and debounce-length constants.
package pb_debounce_pkg;

  typedef enum logic [1:0] {
    LO_STABLE = 2'b00,
    LO_CHK    = 2'b01,
    HI_STABLE = 2'b10,
    HI_CHK    = 2'b11
  } db_state_e;

  localparam int STABLE_CYCLES_DEF = 1000000;
  localparam int STABLE_CYCLES_SIM = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs.
// Resets to 0; only q_o is safe to use in the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/pb_debounce.sv
// Pushbutton debouncer: synchroniser, stability FSM and
// registered level plus one-cycle press/release pulses.
import pb_debounce_pkg::*;

module pb_debounce #(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int CNT_W = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic pb_raw,
  output logic db_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(STABLE_CYCLES - 1);

  logic             s2;
  db_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             press_q;
  logic             release_q;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (pb_raw),
    .q_o   (s2)
  );

  // cnt_q counts consecutive edges s2 differs from level_q
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= LO_STABLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      unique case (state_q)
        LO_STABLE: begin
          if (s2) begin
            state_q <= LO_CHK;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q   <= '0;
          end
        end
        LO_CHK: begin
          if (!s2) begin
            state_q <= LO_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= HI_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        HI_STABLE: begin
          if (!s2) begin
            state_q <= HI_CHK;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q   <= '0;
          end
        end
        HI_CHK: begin
          if (s2) begin
            state_q <= HI_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= LO_STABLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q     <= cnt_q + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign db_level      = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: tb/tb_pb_debounce.sv
// Randomised scoreboard bench for pb_debounce against a
// run-length reference model.
import pb_debounce_pkg::*;

module tb_pb_debounce;

  localparam int S = STABLE_CYCLES_SIM;

  typedef struct packed {
    logic lvl;
    logic pr;
    logic rl;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic pb_raw;
  logic db_level;
  logic press_pulse;
  logic release_pulse;

  int tests = 0;
  int fails = 0;

  exp_t expq[$];
  logic hist[$];
  logic m_level;
  int   m_run;

  pb_debounce #(.STABLE_CYCLES(S)) dut (
    .clk           (clk),
    .reset         (reset),
    .pb_raw        (pb_raw),
    .db_level      (db_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  always #5 clk = ~clk;

  // Model: the level flips once the 2-edge-delayed input has
  // disagreed with it for S consecutive edges.
  always @(posedge reset) begin
    m_level = 1'b0;
    m_run   = 0;
    hist    = {};
    hist.push_back(1'b0);
    hist.push_back(1'b0);
    if (expq.size() > 0)
      expq[expq.size()-1] = '0;
  end

  always @(posedge clk) begin
    exp_t e;
    logic s;
    e = '0;
    if (!reset) begin
      s = hist.pop_front();
      hist.push_back(pb_raw);
      if (s != m_level) begin
        m_run++;
        if (m_run == S) begin
          m_level = s;
          m_run   = 0;
          e.pr    = s;
          e.rl    = !s;
        end
      end else begin
        m_run = 0;
      end
      e.lvl = m_level;
    end
    expq.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a = {db_level, press_pulse, release_pulse};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL sb_out t=%0t lvl/pr/rl got %b%b%b want %b%b%b",
                 $time, a.lvl, a.pr, a.rl, e.lvl, e.pr, e.rl);
      end
    end
  end

  task automatic drive(input logic v, input int n);
    pb_raw = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string nm, input logic [2:0] act,
                       input logic [2:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s got %b want %b", nm, act, want);
    end
  endtask

  initial begin
    int n;
    reset  = 1'b1;
    pb_raw = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_state",
          {db_level, press_pulse, release_pulse}, 3'b000);
    reset = 1'b0;

    drive(1'b0, 20);
    // Clean press: first sampling edge counts as 1
    pb_raw = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (press_pulse && n == 0) n = i;
    end
    #1;
    check("press_latency", 3'(n == S + 2), 3'b001);
    drive(1'b1, 10);

    // Clean release
    drive(1'b0, 30);

    // Bounce then settle high, then release
    drive(1'b1, 3); drive(1'b0, 2);
    drive(1'b1, 5); drive(1'b0, 2);
    drive(1'b1, 7); drive(1'b0, 2);
    drive(1'b1, 30);
    drive(1'b0, 30);

    // Glitch just below and exactly at threshold
    drive(1'b1, S - 1);
    drive(1'b0, 20);
    drive(1'b1, S);
    drive(1'b0, 20);
    drive(1'b1, 30);
    drive(1'b0, S - 1);
    drive(1'b1, 20);

    // Reset mid-count while level is high
    drive(1'b0, 7);
    reset = 1'b1;
    #1;
    check("reset_async",
          {db_level, press_pulse, release_pulse}, 3'b000);
    #1;
    drive(1'b1, 2);
    reset = 1'b0;
    drive(1'b1, 30);
    drive(1'b0, 30);

    for (int i = 0; i < 150; i++)
      drive(1'($urandom_range(0, 1)), $urandom_range(1, 14));

    drive(1'b0, 30);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
